// File: rtl/hdc_pkg.sv
// Shared dimensions and FSM state encoding for the class hypervector trainer.
package hdc_pkg;

  localparam int HV_DIM          = 5000;
  localparam int SEQ_CYCLE_COUNT = 10;
  localparam int DIMS_PER_CC     = 500;
  localparam int CTR_W           = 8;
  localparam int NUM_CLASSES     = 26;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCUM    = 2'd1,
    BINARIZE = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/am_seg_counter_bank.sv
// One class worth of saturating per-dimension counters, organised as segments
// so that a whole segment can be incremented or thresholded in one cycle.
module am_seg_counter_bank
  import hdc_pkg::*;
#(
  parameter int SEGS  = SEQ_CYCLE_COUNT,
  parameter int DPC   = DIMS_PER_CC,
  parameter int CW    = CTR_W,
  parameter int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             add_en,
  input  logic [SEG_W-1:0] add_seg,
  input  logic [DPC-1:0]   add_bits,
  input  logic [SEG_W-1:0] cmp_seg,
  input  logic [CW-1:0]    threshold,
  output logic [DPC-1:0]   cmp_bits
);

  logic [CW-1:0] cnt [SEGS][DPC];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned s = 0; s < SEGS; s++)
        for (int unsigned j = 0; j < DPC; j++)
          cnt[s][j] <= '0;
    end else if (add_en) begin
      for (int unsigned j = 0; j < DPC; j++)
        if (add_bits[j] && (cnt[add_seg][j] != '1))
          cnt[add_seg][j] <= cnt[add_seg][j] + CW'(1);
    end
  end

  // A zero threshold yields all ones because every counter is >= 0.
  always_comb begin
    cmp_bits = '0;
    for (int unsigned j = 0; j < DPC; j++)
      cmp_bits[j] = (cnt[cmp_seg][j] >= threshold);
  end

endmodule

// File: rtl/am_class_hv_trainer.sv
// Accumulates labelled training hypervectors into per-class counters and
// binarizes them, one segment per cycle, into the associative-memory layout.
module am_class_hv_trainer #(
  parameter int HV_DIM          = hdc_pkg::HV_DIM,
  parameter int SEQ_CYCLE_COUNT = hdc_pkg::SEQ_CYCLE_COUNT,
  parameter int DIMS_PER_CC     = hdc_pkg::DIMS_PER_CC,
  parameter int CTR_W           = hdc_pkg::CTR_W
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        en,
  input  logic                                        train_valid,
  output logic                                        train_ready,
  input  logic [HV_DIM-1:0]                           training_hv,
  input  logic [4:0]                                  train_label,
  input  logic                                        finalize,
  input  logic [CTR_W-1:0]                            threshold,
  input  logic                                        clear_model,
  output logic [SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] binary_class_hvs [0:hdc_pkg::NUM_CLASSES-1],
  output logic                                        class_hvs_valid,
  output logic [10:0]                                 sample_count,
  output logic                                        label_err
);
  import hdc_pkg::*;

  localparam int SEG_W = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1;
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(SEQ_CYCLE_COUNT - 1);
  localparam logic [4:0]       LAST_CLS = 5'(NUM_CLASSES - 1);

  state_t                                  state;
  logic [SEG_W-1:0]                        seg_ctr;
  logic [4:0]                              cls_ctr;
  logic [SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] hv_q;
  logic [4:0]                              label_q;
  logic [CTR_W-1:0]                        thr_q;
  logic                                    idle_like;
  logic                                    label_ok;
  logic                                    bank_clr;
  logic [DIMS_PER_CC-1:0]                  cmp_all [NUM_CLASSES];

  assign idle_like   = (state == IDLE) || (state == DONE);
  assign label_ok    = (label_q <= LAST_CLS);
  assign train_ready = !rst && en && idle_like && !finalize && !clear_model;
  assign bank_clr    = rst || (en && idle_like && clear_model);

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_bank
    am_seg_counter_bank #(
      .SEGS  (SEQ_CYCLE_COUNT),
      .DPC   (DIMS_PER_CC),
      .CW    (CTR_W),
      .SEG_W (SEG_W)
    ) u_bank (
      .clk       (clk),
      .clr       (bank_clr),
      .add_en    (en && (state == ACCUM) && label_ok && (label_q == 5'(c))),
      .add_seg   (seg_ctr),
      .add_bits  (hv_q[seg_ctr]),
      .cmp_seg   (seg_ctr),
      .threshold (thr_q),
      .cmp_bits  (cmp_all[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      seg_ctr         <= '0;
      cls_ctr         <= '0;
      hv_q            <= '0;
      label_q         <= '0;
      thr_q           <= '0;
      class_hvs_valid <= 1'b0;
      sample_count    <= '0;
      label_err       <= 1'b0;
      for (int unsigned c = 0; c < NUM_CLASSES; c++)
        binary_class_hvs[c] <= '0;
    end else if (en) begin
      case (state)
        IDLE, DONE: begin
          // clear_model > finalize > accept; train_ready already excludes the first two
          if (clear_model) begin
            state           <= IDLE;
            class_hvs_valid <= 1'b0;
            sample_count    <= '0;
            label_err       <= 1'b0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++)
              binary_class_hvs[c] <= '0;
          end else if (finalize) begin
            state           <= BINARIZE;
            thr_q           <= threshold;
            class_hvs_valid <= 1'b0;
            seg_ctr         <= '0;
            cls_ctr         <= '0;
          end else if (train_valid) begin
            state           <= ACCUM;
            hv_q            <= training_hv;
            label_q         <= train_label;
            class_hvs_valid <= 1'b0;
            seg_ctr         <= '0;
            if (train_label > LAST_CLS)
              label_err <= 1'b1;
          end
        end
        ACCUM: begin
          if (seg_ctr == LAST_SEG) begin
            seg_ctr <= '0;
            state   <= IDLE;
            if (label_ok && (sample_count != '1))
              sample_count <= sample_count + 11'd1;
          end else begin
            seg_ctr <= seg_ctr + SEG_W'(1);
          end
        end
        BINARIZE: begin
          binary_class_hvs[cls_ctr][seg_ctr] <= cmp_all[cls_ctr];
          if (seg_ctr == LAST_SEG) begin
            seg_ctr <= '0;
            if (cls_ctr == LAST_CLS) begin
              cls_ctr         <= '0;
              state           <= DONE;
              class_hvs_valid <= 1'b1;
            end else begin
              cls_ctr <= cls_ctr + 5'd1;
            end
          end else begin
            seg_ctr <= seg_ctr + SEG_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am_class_hv_trainer.sv
// Randomized and directed checks of the class trainer against an array-based model.
module tb_am_class_hv_trainer;

  localparam int SEQ = 10;
  localparam int DPC = 16;
  localparam int HV  = SEQ * DPC;
  localparam int CW  = 8;
  localparam int NC  = 26;
  localparam int CMAX = (1 << CW) - 1;

  logic                         clk = 1'b0;
  logic                         rst, en, train_valid, train_ready;
  logic [HV-1:0]                training_hv;
  logic [4:0]                   train_label;
  logic                         finalize, clear_model;
  logic [CW-1:0]                threshold;
  logic [SEQ-1:0][DPC-1:0]      bch [0:NC-1];
  logic                         class_hvs_valid;
  logic [10:0]                  sample_count;
  logic                         label_err;

  int checks = 0;
  int errors = 0;

  int          mcnt [NC][HV];
  logic [HV-1:0] mbin [NC];
  int          msc;
  bit          mlerr, mvalid;

  am_class_hv_trainer #(
    .HV_DIM          (HV),
    .SEQ_CYCLE_COUNT (SEQ),
    .DIMS_PER_CC     (DPC),
    .CTR_W           (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .train_valid      (train_valid),
    .train_ready      (train_ready),
    .training_hv      (training_hv),
    .train_label      (train_label),
    .finalize         (finalize),
    .threshold        (threshold),
    .clear_model      (clear_model),
    .binary_class_hvs (bch),
    .class_hvs_valid  (class_hvs_valid),
    .sample_count     (sample_count),
    .label_err        (label_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [HV-1:0] act, input logic [HV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < HV; i++) mcnt[c][i] = 0;
      mbin[c] = '0;
    end
    msc = 0; mlerr = 0; mvalid = 0;
  endtask

  task automatic model_accept(input logic [HV-1:0] hv, input int lab);
    mvalid = 0;
    if (lab < NC) begin
      for (int i = 0; i < HV; i++)
        if (hv[i] && mcnt[lab][i] < CMAX) mcnt[lab][i]++;
      if (msc < 2047) msc++;
    end else begin
      mlerr = 1;
    end
  endtask

  task automatic compare_model(input string tag, input bit with_bins);
    logic [HV-1:0] v;
    check_eq({tag, "_valid"}, HV'(class_hvs_valid), HV'(mvalid));
    check_eq({tag, "_count"}, HV'(sample_count), HV'(msc));
    check_eq({tag, "_lerr"}, HV'(label_err), HV'(mlerr));
    if (with_bins)
      for (int c = 0; c < NC; c++) begin
        v = bch[c];
        check_eq($sformatf("%s_bin_c%0d", tag, c), v, mbin[c]);
      end
  endtask

  // Waits for readiness, offers one sample, returns cycles from accept until ready again.
  task automatic train(input logic [HV-1:0] hv, input logic [4:0] lab, output int acc);
    int n = 0;
    while (!train_ready && n < 100) begin tick(); n++; end
    if (!train_ready) check_eq("ready_timeout", HV'(train_ready), HV'(1));
    training_hv = hv; train_label = lab; train_valid = 1'b1;
    tick();
    train_valid = 1'b0;
    model_accept(hv, int'(lab));
    acc = 0;
    while (!train_ready && acc < 100) begin tick(); acc++; end
  endtask

  // Returns cycles from the finalize edge until class_hvs_valid is seen.
  task automatic do_finalize(input logic [CW-1:0] thr, output int n);
    finalize = 1'b1; threshold = thr;
    tick();
    finalize = 1'b0;
    n = 1;
    while (!class_hvs_valid && n < 400) begin tick(); n++; end
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < HV; i++) mbin[c][i] = (mcnt[c][i] >= int'(thr));
    mvalid = 1;
  endtask

  task automatic do_clear();
    clear_model = 1'b1;
    tick();
    clear_model = 1'b0;
    model_clear();
  endtask

  function automatic logic [HV-1:0] rand_hv();
    logic [HV-1:0] v;
    for (int i = 0; i < HV; i++) v[i] = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  initial begin
    int acc, fin, n;
    logic [HV-1:0] hv;
    rst = 1'b1; en = 1'b1; train_valid = 1'b0; training_hv = '0; train_label = '0;
    finalize = 1'b0; threshold = '0; clear_model = 1'b0;
    model_clear();
    tick(); tick();
    check_eq("ready_in_rst", HV'(train_ready), HV'(0));
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", HV'(train_ready), HV'(1));
    compare_model("reset", 1'b1);

    // single all-ones sample, class 3, threshold 1
    train('1, 5'd3, acc);
    check_eq("accum_cycles", HV'(acc), HV'(10));
    do_finalize(8'd1, fin);
    check_eq("bin_cycles", HV'(fin), HV'(261));
    check_eq("accept_to_valid", HV'(acc + fin), HV'(271));
    compare_model("one_sample", 1'b1);

    // out-of-range label: accepted, no counter or count change
    train(rand_hv(), 5'd30, acc);
    check_eq("bad_label_accum", HV'(acc), HV'(10));
    compare_model("bad_label", 1'b0);
    do_finalize(8'd1, fin);
    compare_model("bad_label_fin", 1'b1);

    // clear + finalize + train_valid together in DONE: clear wins
    clear_model = 1'b1; finalize = 1'b1; threshold = 8'd1;
    training_hv = '1; train_label = 5'd5; train_valid = 1'b1;
    tick();
    clear_model = 1'b0; finalize = 1'b0; train_valid = 1'b0;
    model_clear();
    compare_model("clear_prio", 1'b1);
    tick();
    check_eq("clear_prio_idle", HV'(train_ready), HV'(1));
    do_finalize(8'd1, fin);
    compare_model("clear_prio_fin", 1'b1);

    // saturation: 300 samples with bit 0, threshold 255
    do_clear();
    hv = '0; hv[0] = 1'b1;
    for (int k = 0; k < 300; k++) train(hv, 5'd0, acc);
    check_eq("sat_model_cnt", HV'(sample_count), HV'(300));
    do_finalize(8'd255, fin);
    check_eq("sat_bit0", HV'(bch[0][0][0]), HV'(1));
    compare_model("saturate", 1'b1);

    // random samples, some with out-of-range labels
    do_clear();
    for (int k = 0; k < 60; k++) train(rand_hv(), 5'($urandom_range(0, 31)), acc);
    do_finalize(8'($urandom_range(1, 3)), fin);
    compare_model("random", 1'b1);
    do_finalize(8'd0, fin);
    compare_model("thr_zero", 1'b1);

    // enable pause in the middle of ACCUM
    hv = rand_hv();
    while (!train_ready) tick();
    training_hv = hv; train_label = 5'd7; train_valid = 1'b1;
    tick();
    train_valid = 1'b0;
    model_accept(hv, 7);
    n = 0;
    repeat (4) begin tick(); n++; end
    en = 1'b0;
    #1;
    check_eq("ready_en_low", HV'(train_ready), HV'(0));
    repeat (5) begin tick(); n++; end
    en = 1'b1;
    while (!train_ready && n < 100) begin tick(); n++; end
    check_eq("paused_accum_cycles", HV'(n), HV'(15));
    do_finalize(8'd1, fin);
    compare_model("paused", 1'b1);

    // reset during BINARIZE
    finalize = 1'b1; threshold = 8'd1;
    tick();
    finalize = 1'b0;
    repeat (99) tick();
    check_eq("mid_bin_valid", HV'(class_hvs_valid), HV'(0));
    rst = 1'b1;
    tick();
    model_clear();
    check_eq("rst_ready", HV'(train_ready), HV'(0));
    compare_model("mid_bin_rst", 1'b1);
    rst = 1'b0;
    #1;
    check_eq("rst_release_ready", HV'(train_ready), HV'(1));
    train(rand_hv(), 5'd2, acc);
    do_finalize(8'd1, fin);
    compare_model("after_rst", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
